// File: rtl/mdu_ctrl.sv
// RV32M multiply/divide sequencer for the EX stage: 32-cycle shift-add multiply
// or restoring divide on operand magnitudes, then sign fix-up and a held result.
module mdu_ctrl #(
  parameter logic DIV_ZERO_FAST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        kill,
  input  logic        ready_mem,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;

  state_t      state_q, state_d;
  op_t         op_q;
  logic [4:0]  cnt_q;
  logic        sa_q, sb_q, dz_q, valid_q;
  // hi_q/lo_q: product {hi,lo} when multiplying, remainder R / quotient Q when dividing
  logic [31:0] hi_q, lo_q, b_q, a_raw_q, result_q;

  logic        accept, a_signed, b_signed, is_div;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, rem_sh;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic [63:0] prod, prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_result;

  assign accept   = (state_q == IDLE) && start && !kill;
  assign is_div   = op[2];
  assign a_signed = (!op[2] && (op[1:0] != 2'd3)) || (op[2] && !op[0]);
  assign b_signed = (!op[2] && !op[1])           || (op[2] && !op[0]);
  assign a_mag    = (a_signed && src_a[31]) ? -src_a : src_a;
  assign b_mag    = (b_signed && src_b[31]) ? -src_b : src_b;

  // One iteration of each algorithm; R always stays below |b|, so 32 bits hold it.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
  assign rem_sh  = {hi_q, lo_q[31]};
  assign rem_ge  = rem_sh >= {1'b0, b_q};
  assign rem_sub = rem_sh[31:0] - b_q;

  assign prod     = {hi_q, lo_q};
  assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;
  assign quo_fix  = (sa_q ^ sb_q) ? -lo_q : lo_q;
  assign rem_fix  = sa_q ? -hi_q : hi_q;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    fix_result = prod_fix[63:32];
    case (op_q)
      OP_MUL:          fix_result = prod_fix[31:0];
      OP_DIV, OP_DIVU: fix_result = dz_q ? 32'hFFFF_FFFF : quo_fix;
      OP_REM, OP_REMU: fix_result = dz_q ? a_raw_q : rem_fix;
      default:         fix_result = prod_fix[63:32];
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept)
               state_d = (DIV_ZERO_FAST && is_div && (src_b == 32'd0)) ? FIXUP : CALC;
      CALC:  if (cnt_q == 5'd31) state_d = FIXUP;
      FIXUP: state_d = DONE;
      DONE:  if (ready_mem) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  assign busy = accept || (state_q == CALC) || (state_q == FIXUP) ||
                ((state_q == DONE) && !ready_mem);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OP_MUL;
      cnt_q    <= 5'd0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      b_q      <= 32'd0;
      a_raw_q  <= 32'd0;
      result_q <= 32'd0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= (state_d == DONE);
      if (accept) begin
        op_q    <= op_t'(op);
        sa_q    <= a_signed && src_a[31];
        sb_q    <= b_signed && src_b[31];
        dz_q    <= is_div && (src_b == 32'd0);
        hi_q    <= 32'd0;
        lo_q    <= a_mag;
        b_q     <= b_mag;
        a_raw_q <= src_a;
        cnt_q   <= 5'd0;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + 5'd1;
        if (op_q[2]) begin
          hi_q <= rem_ge ? rem_sub : rem_sh[31:0];
          lo_q <= {lo_q[30:0], rem_ge};
        end else begin
          hi_q <= mul_sum[32:1];
          lo_q <= {mul_sum[0], lo_q[31:1]};
        end
      end else if ((state_q == FIXUP) && !kill) begin
        result_q <= fix_result;
      end
    end
  end

  assign result_valid = valid_q;
  assign result       = result_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, randomized ops against
// a plain-arithmetic reference model, and hand-written abort/reset sequences.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, kill, ready_mem, use_slow;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;

  logic        start_f, ready_f, busy_f, valid_f;
  logic        start_s, ready_s, busy_s, valid_s;
  logic [31:0] result_f, result_s;
  logic        busy_m, valid_m;
  logic [31:0] result_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign start_f  = start & ~use_slow;
  assign ready_f  = ready_mem & ~use_slow;
  assign start_s  = start & use_slow;
  assign ready_s  = ready_mem & use_slow;
  assign busy_m   = use_slow ? busy_s   : busy_f;
  assign valid_m  = use_slow ? valid_s  : valid_f;
  assign result_m = use_slow ? result_s : result_f;

  mdu_ctrl #(.DIV_ZERO_FAST(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start_f), .op(op), .src_a(src_a), .src_b(src_b),
    .kill(kill), .ready_mem(ready_f), .busy(busy_f), .result_valid(valid_f), .result(result_f)
  );

  mdu_ctrl #(.DIV_ZERO_FAST(1'b0)) dut_slow (
    .clk(clk), .reset(reset), .start(start_s), .op(op), .src_a(src_a), .src_b(src_b),
    .kill(kill), .ready_mem(ready_s), .busy(busy_s), .result_valid(valid_s), .result(result_s)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    logic        slow;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // RV32M semantics straight from the architectural definition.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa_l, sb_l, p;
    logic [63:0] pu;
    sa_l = {{32{a[31]}}, a};
    sb_l = {{32{b[31]}}, b};
    case (o)
      3'd0: begin p = sa_l * sb_l; return p[31:0]; end
      3'd1: begin p = sa_l * sb_l; return p[63:32]; end
      3'd2: begin p = sa_l * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Issue one op, measure start-to-valid latency, hold DONE for 'hold' cycles, then retire it.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                       input int hold);
    int          lat;
    bit          busy_ok;
    logic [31:0] held;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; ready_mem = 1'b0;
    #1 check({tag, " busy_in_start_cycle"}, busy_m, 1);
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 1; busy_ok = 1'b1;
    while (!valid_m && lat < 100) begin
      if (!busy_m) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_until_valid"}, busy_ok, 1);
    if (valid_m) begin
      check({tag, " result"}, result_m, exp);
      held = result_m;
      for (int i = 0; i < hold; i++) begin
        check({tag, " hold_valid"}, valid_m, 1);
        check({tag, " hold_result"}, result_m, held);
        check({tag, " hold_busy"}, busy_m, 1);
        @(negedge clk);
      end
      ready_mem = 1'b1;
      #1 check({tag, " busy_drops_on_accept"}, busy_m, 0);
      @(negedge clk);
      ready_mem = 1'b0;
      check({tag, " idle_after_accept_valid"}, valid_m, 0);
      check({tag, " idle_after_accept_busy"}, busy_m, 0);
    end
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b0};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b0};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, 1'b0};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, 1'b0};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        34, 1'b0};
    vecs[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b0};
    vecs[8]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 1'b0};
    vecs[9]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 2,  1'b0};
    vecs[10] = '{3'd7, 32'h0000_1234, 32'd0,         32'h0000_1234, 2,  1'b0};
    vecs[11] = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 34, 1'b1};
    vecs[12] = '{3'd7, 32'h0000_1234, 32'd0,         32'h0000_1234, 34, 1'b1};
    vecs[13] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 2,  1'b0};
    vecs[14] = '{3'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 34, 1'b0};

    reset = 1'b1; start = 1'b0; kill = 1'b0; ready_mem = 1'b0; use_slow = 1'b0;
    op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (2) @(negedge clk);
    check("reset result_valid", valid_f, 0);
    check("reset result", result_f, 0);
    check("reset busy", busy_f, 0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      use_slow = vecs[i].slow;
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].exp, vecs[i].lat, (i == 6) ? 5 : 0);
    end
    use_slow = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(1, 20)); end
        3: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      do_op($sformatf("rnd%0d op%0d", i, o), o, a, b, model(o, a, b),
            (o[2] && b == 32'd0) ? 2 : 34, int'($urandom_range(0, 3)));
    end

    // Kill in the middle of CALC, then an immediate MUL.
    @(negedge clk);
    start = 1'b1; op = 3'd5; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("kill busy_in_calc", busy_f, 1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill idle busy", busy_f, 0);
    check("kill no valid", valid_f, 0);
    begin
      bit seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (valid_f || busy_f) seen = 1'b1;
      end
      check("kill stays idle", seen, 0);
    end
    do_op("post_kill MUL", 3'd0, 32'hFFFF_FF00, 32'd3, 32'hFFFF_FD00, 34, 1);

    // Kill together with start must not be accepted.
    @(negedge clk);
    start = 1'b1; kill = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9;
    #1 check("start_kill busy", busy_f, 0);
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    begin
      bit seen = 1'b0;
      repeat (40) begin
        if (valid_f || busy_f) seen = 1'b1;
        @(negedge clk);
      end
      check("start_kill not accepted", seen, 0);
    end

    // Reset pulse mid-CALC clears everything, including a previously held result.
    @(negedge clk);
    start = 1'b1; op = 3'd0; src_a = 32'd123; src_b = 32'd456;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_mid result_valid", valid_f, 0);
    check("reset_mid result", result_f, 0);
    check("reset_mid busy", busy_f, 0);
    @(negedge clk);
    reset = 1'b0;
    begin
      bit seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (valid_f || busy_f || result_f != 32'd0) seen = 1'b1;
      end
      check("reset_mid stays idle", seen, 0);
    end
    do_op("post_reset DIV", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
